// File: rtl/timer_seq_pkg.sv
// rtl/timer_seq_pkg.sv - state codes, timer register map and bus helpers for timer_irq_sequencer
package timer_seq_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE      = 4'd0;
  localparam state_t S_STOP_WR   = 4'd1;
  localparam state_t S_CLR_WR    = 4'd2;
  localparam state_t S_PERL_WR   = 4'd3;
  localparam state_t S_PERH_WR   = 4'd4;
  localparam state_t S_CTRL_WR   = 4'd5;
  localparam state_t S_RUN       = 4'd6;
  localparam state_t S_ACK_WR    = 4'd7;
  localparam state_t S_SNAP_WR   = 4'd8;
  localparam state_t S_SNAP_RDL  = 4'd9;
  localparam state_t S_SNAP_RDH  = 4'd10;
  localparam state_t S_SNAP_DONE = 4'd11;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
  localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
  localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  typedef struct packed {
    logic        cs;
    logic        write_n;
    logic [2:0]  addr;
    logic [15:0] data;
  } bus_t;

  localparam bus_t BUS_IDLE = '{cs: 1'b0, write_n: 1'b1, addr: 3'd0, data: 16'd0};

  function automatic bus_t bus_wr(input logic [2:0] a, input logic [15:0] d);
    bus_t b;
    b.cs      = 1'b1;
    b.write_n = 1'b0;
    b.addr    = a;
    b.data    = d;
    return b;
  endfunction

  function automatic bus_t bus_rd(input logic [2:0] a);
    bus_t b;
    b.cs      = 1'b1;
    b.write_n = 1'b1;
    b.addr    = a;
    b.data    = 16'd0;
    return b;
  endfunction

  function automatic logic [15:0] ctrl_start_word(input logic cont);
    logic [15:0] w;
    w             = 16'd0;
    w[CTRL_ITO]   = 1'b1;
    w[CTRL_CONT]  = cont;
    w[CTRL_START] = 1'b1;
    return w;
  endfunction

  function automatic logic [15:0] ctrl_stop_word();
    logic [15:0] w;
    w            = 16'd0;
    w[CTRL_STOP] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/timer_irq_sequencer.sv
// rtl/timer_irq_sequencer.sv - programs and services an Avalon interval timer; snapshot readback under TIMER_SEQ_SNAPSHOT_EN
module timer_irq_sequencer
  import timer_seq_pkg::*;
#(
  parameter int TICK_W     = 16,
  parameter int MIN_PERIOD = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [31:0]       cfg_period,
  input  logic              cfg_continuous,
  input  logic              stop_req,
  output logic              running,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic [2:0]        tmr_address,
  output logic              tmr_chipselect,
  output logic              tmr_write_n,
  output logic [15:0]       tmr_writedata,
  input  logic [15:0]       tmr_readdata,
  input  logic              tmr_irq
`ifdef TIMER_SEQ_SNAPSHOT_EN
  ,
  input  logic              snap_req,
  output logic              snap_valid,
  output logic [31:0]       snap_value
`endif
);

  state_t            state_q, state_d;
  logic [31:0]       period_q, period_d;
  logic              cont_q, cont_d;
  logic              seq_cfg_q, seq_cfg_d;
  logic              stop_pend_q, stop_pend_d;
  logic              tick_q, tick_d;
  logic [TICK_W-1:0] cnt_q, cnt_d;
  bus_t              bus_q, bus_d;
  logic              stop_clr;
  logic              snap_block;
  logic              accept;

`ifdef TIMER_SEQ_SNAPSHOT_EN
  logic        snap_pend_q, snap_pend_d;
  logic        snap_clr;
  logic [15:0] snap_lo_q, snap_lo_d;
  logic [31:0] snap_val_q, snap_val_d;
  logic        snap_valid_q, snap_valid_d;
  assign snap_block = snap_pend_q;
`else
  logic unused_readdata;
  assign unused_readdata = ^tmr_readdata;
  assign snap_block      = 1'b0;
`endif

  // A stale irq or a pending stop must win over a new request, so ready is withheld then.
  always_comb begin
    cfg_ready = 1'b0;
    if (!reset) begin
      if (state_q == S_IDLE)
        cfg_ready = !tmr_irq && !stop_pend_q;
      else if (state_q == S_RUN)
        cfg_ready = !tmr_irq && !stop_pend_q && !snap_block;
    end
  end

  assign accept = cfg_valid && cfg_ready;

  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    cont_d    = cont_q;
    seq_cfg_d = seq_cfg_q;
    tick_d    = 1'b0;
    cnt_d     = cnt_q;
    stop_clr  = 1'b0;
`ifdef TIMER_SEQ_SNAPSHOT_EN
    snap_clr     = 1'b0;
    snap_lo_d    = snap_lo_q;
    snap_val_d   = snap_val_q;
    snap_valid_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (tmr_irq) begin
          state_d   = S_STOP_WR;
          seq_cfg_d = 1'b0;
        end else if (stop_pend_q) begin
          stop_clr = 1'b1;
        end else if (accept) begin
          state_d   = S_STOP_WR;
          seq_cfg_d = 1'b1;
          period_d  = (cfg_period < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : cfg_period;
          cont_d    = cfg_continuous;
        end
      end
      S_STOP_WR: state_d = S_CLR_WR;
      S_CLR_WR: begin
        if (seq_cfg_q) begin
          state_d = S_PERL_WR;
        end else begin
          state_d  = S_IDLE;
          stop_clr = 1'b1;
        end
      end
      S_PERL_WR: state_d = S_PERH_WR;
      S_PERH_WR: state_d = S_CTRL_WR;
      S_CTRL_WR: begin
        if (stop_pend_q) begin
          state_d   = S_STOP_WR;
          seq_cfg_d = 1'b0;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (tmr_irq) begin
          state_d = S_ACK_WR;
        end else if (stop_pend_q) begin
          state_d   = S_STOP_WR;
          seq_cfg_d = 1'b0;
`ifdef TIMER_SEQ_SNAPSHOT_EN
        end else if (snap_pend_q) begin
          state_d  = S_SNAP_WR;
          snap_clr = 1'b1;
`endif
        end else if (accept) begin
          state_d   = S_STOP_WR;
          seq_cfg_d = 1'b1;
          period_d  = (cfg_period < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : cfg_period;
          cont_d    = cfg_continuous;
        end
      end
      S_ACK_WR: begin
        tick_d  = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        state_d = cont_q ? S_RUN : S_IDLE;
      end
`ifdef TIMER_SEQ_SNAPSHOT_EN
      S_SNAP_WR:  state_d = S_SNAP_RDL;
      S_SNAP_RDL: state_d = S_SNAP_RDH;
      // readdata lags the address by one cycle, so each half is taken one state later
      S_SNAP_RDH: begin
        snap_lo_d = tmr_readdata;
        state_d   = S_SNAP_DONE;
      end
      S_SNAP_DONE: begin
        snap_val_d   = {tmr_readdata, snap_lo_q};
        snap_valid_d = 1'b1;
        state_d      = S_RUN;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign stop_pend_d = stop_req || (stop_pend_q && !stop_clr);
`ifdef TIMER_SEQ_SNAPSHOT_EN
  assign snap_pend_d = snap_req || (snap_pend_q && !snap_clr);
`endif

  // Bus registers are loaded with the access belonging to the state being entered.
  always_comb begin
    bus_d = BUS_IDLE;
    case (state_d)
      S_STOP_WR:   bus_d = bus_wr(ADDR_CONTROL, ctrl_stop_word());
      S_CLR_WR:    bus_d = bus_wr(ADDR_STATUS, 16'd0);
      S_PERL_WR:   bus_d = bus_wr(ADDR_PERIOD_L, period_d[15:0]);
      S_PERH_WR:   bus_d = bus_wr(ADDR_PERIOD_H, period_d[31:16]);
      S_CTRL_WR:   bus_d = bus_wr(ADDR_CONTROL, ctrl_start_word(cont_d));
      S_ACK_WR:    bus_d = bus_wr(ADDR_STATUS, 16'd0);
`ifdef TIMER_SEQ_SNAPSHOT_EN
      S_SNAP_WR:   bus_d = bus_wr(ADDR_SNAP_L, 16'd0);
      S_SNAP_RDL:  bus_d = bus_rd(ADDR_SNAP_L);
      S_SNAP_RDH:  bus_d = bus_rd(ADDR_SNAP_H);
`endif
      default:     bus_d = BUS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      period_q    <= '0;
      cont_q      <= 1'b0;
      seq_cfg_q   <= 1'b0;
      stop_pend_q <= 1'b0;
      tick_q      <= 1'b0;
      cnt_q       <= '0;
      bus_q       <= BUS_IDLE;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      cont_q      <= cont_d;
      seq_cfg_q   <= seq_cfg_d;
      stop_pend_q <= stop_pend_d;
      tick_q      <= tick_d;
      cnt_q       <= cnt_d;
      bus_q       <= bus_d;
    end
  end

`ifdef TIMER_SEQ_SNAPSHOT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_pend_q  <= 1'b0;
      snap_lo_q    <= '0;
      snap_val_q   <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      snap_pend_q  <= snap_pend_d;
      snap_lo_q    <= snap_lo_d;
      snap_val_q   <= snap_val_d;
      snap_valid_q <= snap_valid_d;
    end
  end

  assign snap_valid = snap_valid_q;
  assign snap_value = snap_val_q;
`endif

  assign running        = (state_q == S_RUN) || (state_q == S_ACK_WR);
  assign tick           = tick_q;
  assign tick_count     = cnt_q;
  assign tmr_chipselect = bus_q.cs;
  assign tmr_write_n    = bus_q.write_n;
  assign tmr_address    = bus_q.addr;
  assign tmr_writedata  = bus_q.data;

endmodule

// File: tb/tb_timer_irq_sequencer.sv
// tb/tb_timer_irq_sequencer.sv - self-checking bench for timer_irq_sequencer with a behavioural interval timer
module tb_timer_irq_sequencer;

  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [31:0]   cfg_period;
  logic          cfg_continuous;
  logic          stop_req;
  logic          running;
  logic          tick;
  logic [TW-1:0] tick_count;
  logic [2:0]    tmr_address;
  logic          tmr_chipselect;
  logic          tmr_write_n;
  logic [15:0]   tmr_writedata;
  logic [15:0]   tmr_readdata;
  logic          tmr_irq;
`ifdef TIMER_SEQ_SNAPSHOT_EN
  logic          snap_req;
  logic          snap_valid;
  logic [31:0]   snap_value;
`endif

  always #5 clk = ~clk;

  timer_irq_sequencer #(.TICK_W(TW), .MIN_PERIOD(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_period     (cfg_period),
    .cfg_continuous (cfg_continuous),
    .stop_req       (stop_req),
    .running        (running),
    .tick           (tick),
    .tick_count     (tick_count),
    .tmr_address    (tmr_address),
    .tmr_chipselect (tmr_chipselect),
    .tmr_write_n    (tmr_write_n),
    .tmr_writedata  (tmr_writedata),
    .tmr_readdata   (tmr_readdata),
    .tmr_irq        (tmr_irq)
`ifdef TIMER_SEQ_SNAPSHOT_EN
    ,
    .snap_req       (snap_req),
    .snap_valid     (snap_valid),
    .snap_value     (snap_value)
`endif
  );

  // Behavioural interval timer; not reset by the sequencer reset.
  logic        m_rst, m_hold, m_load;
  logic [31:0] m_load_val;
  logic [31:0] m_cnt;
  logic [15:0] m_per_l, m_per_h, m_snap_l, m_snap_h, m_rd;
  logic        m_run, m_cont, m_ito, m_to;

  always @(posedge clk) begin
    if (m_rst) begin
      m_cnt <= 0; m_per_l <= 0; m_per_h <= 0; m_snap_l <= 0; m_snap_h <= 0;
      m_run <= 0; m_cont <= 0; m_ito <= 0; m_to <= 0; m_rd <= 0;
    end else begin
      if (m_load) m_cnt <= m_load_val;
      else if (m_run && !m_hold) begin
        if (m_cnt == 0) begin
          m_cnt <= {m_per_h, m_per_l};
          if (!m_cont) m_run <= 1'b0;
        end else m_cnt <= m_cnt - 1;
      end
      if (tmr_chipselect && !tmr_write_n) begin
        case (tmr_address)
          3'd0: m_to <= 1'b0;
          3'd1: begin
            m_ito  <= tmr_writedata[0];
            m_cont <= tmr_writedata[1];
            if (tmr_writedata[2]) begin m_run <= 1'b1; m_cnt <= {m_per_h, m_per_l}; end
            if (tmr_writedata[3]) m_run <= 1'b0;
          end
          3'd2: m_per_l <= tmr_writedata;
          3'd3: m_per_h <= tmr_writedata;
          3'd4: begin m_snap_l <= m_cnt[15:0]; m_snap_h <= m_cnt[31:16]; end
          default: ;
        endcase
      end
      if (m_run && !m_hold && !m_load && m_cnt == 0) m_to <= 1'b1;
      m_rd <= (tmr_address == 3'd4) ? m_snap_l : (tmr_address == 3'd5) ? m_snap_h : 16'd0;
    end
  end
  assign tmr_irq      = m_to && m_ito;
  assign tmr_readdata = m_rd;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard of expected timer writes, popped by the bus monitor.
  typedef struct packed {
    logic [2:0]  a;
    logic [15:0] d;
  } wr_t;
  wr_t  exp_q[$];
  wr_t  mon_e;
  int   cyc = 0;
  int   last_wr_cyc = 0;
  logic [2:0] last_wr_addr = 3'd7;
  int   ticks_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tmr_chipselect === 1'b1 && tmr_write_n === 1'b0) begin
      last_wr_cyc  = cyc;
      last_wr_addr = tmr_address;
      if (exp_q.size() == 0) begin
        check("wr_unexpected", {13'd0, tmr_address, tmr_writedata}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", {29'd0, tmr_address}, {29'd0, mon_e.a});
        check("wr_data", {16'd0, tmr_writedata}, {16'd0, mon_e.d});
      end
    end
    if (tick === 1'b1) ticks_seen++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_wr(input logic [2:0] a, input logic [15:0] d);
    exp_q.push_back('{a: a, d: d});
  endtask

  task automatic exp_cfg(input logic [15:0] pl, input logic [15:0] ph, input logic [15:0] ctl);
    exp_wr(3'd1, 16'h0008);
    exp_wr(3'd0, 16'h0000);
    exp_wr(3'd2, pl);
    exp_wr(3'd3, ph);
    exp_wr(3'd1, ctl);
  endtask

  task automatic exp_stop();
    exp_wr(3'd1, 16'h0008);
    exp_wr(3'd0, 16'h0000);
  endtask

  task automatic send_cfg(input logic [31:0] p, input logic c);
    int n;
    cfg_period     = p;
    cfg_continuous = c;
    cfg_valid      = 1'b1;
    n = 0;
    while (!cfg_ready && n < 50) begin step(); n++; end
    check("cfg_accept", {31'd0, cfg_ready}, 32'd1);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin step(); n++; end
    check(name, exp_q.size(), 0);
    step();
  endtask

  task automatic do_stop();
    exp_stop();
    stop_req = 1'b1;
    step();
    stop_req = 1'b0;
    drain("stop_drain");
    check("stopped_running", {31'd0, running}, 32'd0);
  endtask

  int exp_cnt = 0;

  task automatic run_ticks(input int nt);
    int n;
    int prev;
    prev = 0;
    for (int k = 0; k < nt; k++) begin
      n = 0;
      do begin step(); n++; end while (tick !== 1'b1 && n < 40);
      check("tick_seen", {31'd0, tick}, 32'd1);
      exp_cnt = (exp_cnt + 1) % (1 << TW);
      check("tick_count", {28'd0, tick_count}, exp_cnt);
      check("ack_before_tick", {29'd0, last_wr_addr}, 32'd0);
      check("ack_lag", cyc - last_wr_cyc, 1);
      if (k > 0) check("tick_spacing", cyc - prev, 10);
      prev = cyc;
    end
  endtask

  typedef struct {
    logic [31:0] per;
    logic        cont;
    logic [15:0] pl;
    logic [15:0] ph;
    logic [15:0] ctl;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int n;
    int t0;
    tbl[0] = '{32'h0001_86A0, 1'b1, 16'h86A0, 16'h0001, 16'h0007};
    tbl[1] = '{32'h0000_0000, 1'b1, 16'h0002, 16'h0000, 16'h0007};
    tbl[2] = '{32'h0000_0001, 1'b0, 16'h0002, 16'h0000, 16'h0005};
    tbl[3] = '{32'h0000_0002, 1'b0, 16'h0002, 16'h0000, 16'h0005};
    tbl[4] = '{32'hFFFF_FFFF, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0007};
    tbl[5] = '{32'h1234_0003, 1'b0, 16'h0003, 16'h1234, 16'h0005};

    reset = 1'b1; m_rst = 1'b1; m_hold = 1'b1; m_load = 1'b0; m_load_val = 0;
    cfg_valid = 1'b0; cfg_period = 0; cfg_continuous = 1'b0; stop_req = 1'b0;
`ifdef TIMER_SEQ_SNAPSHOT_EN
    snap_req = 1'b0;
`endif
    step(); step(); step();
    check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd0);
    check("rst_running", {31'd0, running}, 32'd0);
    check("rst_tick", {31'd0, tick}, 32'd0);
    check("rst_tick_count", {28'd0, tick_count}, 32'd0);
    check("rst_bus", {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}, {1'b0, 1'b1, 3'd0, 16'd0});
    reset = 1'b0; m_rst = 1'b0;
    step();
    check("idle_cfg_ready", {31'd0, cfg_ready}, 32'd1);

    // Programming sequence and clamping, timer frozen so no irq intervenes.
    for (int i = 0; i < 6; i++) begin
      exp_cfg(tbl[i].pl, tbl[i].ph, tbl[i].ctl);
      send_cfg(tbl[i].per, tbl[i].cont);
      check("first_write_latency", {31'd0, tmr_chipselect & ~tmr_write_n}, 32'd1);
      drain("cfg_drain");
      check("cfg_running", {31'd0, running}, 32'd1);
      check("run_cfg_ready", {31'd0, cfg_ready}, 32'd1);
      do_stop();
    end

    // stop_req during PERL_WR: sequence completes, then stops with no tick.
    t0 = ticks_seen;
    exp_cfg(16'h0064, 16'h0000, 16'h0007);
    exp_stop();
    send_cfg(32'd100, 1'b1);
    n = 0;
    while (!(tmr_chipselect && tmr_address == 3'd2) && n < 10) begin step(); n++; end
    stop_req = 1'b1;
    step();
    stop_req = 1'b0;
    drain("perl_stop_drain");
    check("perl_stop_running", {31'd0, running}, 32'd0);
    check("perl_stop_noticks", ticks_seen - t0, 0);
    check("perl_stop_ready", {31'd0, cfg_ready}, 32'd1);

    // Periodic run with a live timer.
    m_hold = 1'b0;
    exp_cfg(16'h0009, 16'h0000, 16'h0007);
    for (int k = 0; k < 3; k++) exp_wr(3'd0, 16'h0000);
    send_cfg(32'd9, 1'b1);
    run_ticks(3);
    do_stop();

    // One-shot: exactly one tick then idle.
    t0 = ticks_seen;
    exp_cfg(16'h0004, 16'h0000, 16'h0005);
    exp_wr(3'd0, 16'h0000);
    send_cfg(32'd4, 1'b0);
    n = 0;
    while (tick !== 1'b1 && n < 40) begin step(); n++; end
    exp_cnt = (exp_cnt + 1) % (1 << TW);
    check("oneshot_tick_count", {28'd0, tick_count}, exp_cnt);
    for (int k = 0; k < 20; k++) step();
    check("oneshot_ticks", ticks_seen - t0, 1);
    check("oneshot_running", {31'd0, running}, 32'd0);
    check("oneshot_irq", {31'd0, tmr_irq}, 32'd0);
    check("oneshot_ready", {31'd0, cfg_ready}, 32'd1);
    check("oneshot_drain", exp_q.size(), 0);

    // irq, stop_req and cfg_valid in the same RUN cycle.
    exp_cfg(16'h0014, 16'h0000, 16'h0007);
    send_cfg(32'd20, 1'b1);
    n = 0;
    while (tmr_irq !== 1'b1 && n < 60) begin step(); n++; end
    check("sim_irq_in_run", {30'd0, tmr_irq, running}, 32'd3);
    t0 = ticks_seen;
    exp_wr(3'd0, 16'h0000);
    exp_stop();
    exp_cfg(16'h0032, 16'h0000, 16'h0007);
    stop_req = 1'b1; cfg_valid = 1'b1; cfg_period = 32'd50; cfg_continuous = 1'b1;
    check("sim_ready_low", {31'd0, cfg_ready}, 32'd0);
    step();
    stop_req = 1'b0;
    n = 0;
    while (!cfg_ready && n < 30) begin step(); n++; end
    check("sim_accept_from_idle", {30'd0, cfg_ready, running}, 32'd2);
    check("sim_tick_first", ticks_seen - t0, 1);
    step();
    cfg_valid = 1'b0;
    drain("sim_drain");
    exp_cnt = (exp_cnt + 1) % (1 << TW);
    check("sim_tick_count", {28'd0, tick_count}, exp_cnt);
    check("sim_running", {31'd0, running}, 32'd1);
    do_stop();

    // Wrap of tick_count from all-ones to zero.
    exp_cfg(16'h0009, 16'h0000, 16'h0007);
    for (int k = 0; k < (1 << TW) - exp_cnt; k++) exp_wr(3'd0, 16'h0000);
    send_cfg(32'd9, 1'b1);
    run_ticks((1 << TW) - exp_cnt);
    check("wrap_zero", {28'd0, tick_count}, 32'd0);
    do_stop();

`ifdef TIMER_SEQ_SNAPSHOT_EN
    m_hold = 1'b1;
    exp_cfg(16'h0000, 16'h0010, 16'h0007);
    send_cfg(32'h0010_0000, 1'b1);
    drain("snap_cfg_drain");
    m_load = 1'b1; m_load_val = 32'h0000_1234;
    step();
    m_load = 1'b0;
    exp_wr(3'd4, 16'h0000);
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    n = 0;
    while (snap_valid !== 1'b1 && n < 20) begin step(); n++; end
    check("snap_valid", {31'd0, snap_valid}, 32'd1);
    check("snap_value", snap_value, 32'h0000_1234);
    step();
    check("snap_valid_once", {31'd0, snap_valid}, 32'd0);
    do_stop();
    m_hold = 1'b0;
`endif

    // Reset mid-sequence abandons the partial write and idles the bus.
    exp_wr(3'd1, 16'h0008);
    exp_wr(3'd0, 16'h0000);
    exp_wr(3'd2, 16'h0009);
    send_cfg(32'd9, 1'b1);
    n = 0;
    while (!(tmr_chipselect && tmr_address == 3'd2) && n < 10) begin step(); n++; end
    reset = 1'b1;
    step();
    check("midrst_bus", {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}, {1'b0, 1'b1, 3'd0, 16'd0});
    check("midrst_ready", {30'd0, cfg_ready, running}, 32'd0);
    reset = 1'b0;
    step();
    check("midrst_drain", exp_q.size(), 0);
    check("midrst_idle_ready", {31'd0, cfg_ready}, 32'd1);

    // Stale irq in IDLE after a sequencer-only reset: cleanup before cfg, no tick.
    exp_cfg(16'h0009, 16'h0000, 16'h0007);
    send_cfg(32'd9, 1'b1);
    drain("stale_cfg_drain");
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_cnt = 0;
    t0 = ticks_seen;
    n = 0;
    while (tmr_irq !== 1'b1 && n < 30) begin step(); n++; end
    check("stale_irq_idle", {30'd0, tmr_irq, running}, 32'd2);
    exp_stop();
    exp_cfg(16'h001E, 16'h0000, 16'h0007);
    cfg_valid = 1'b1; cfg_period = 32'd30; cfg_continuous = 1'b1;
    check("stale_ready_low", {31'd0, cfg_ready}, 32'd0);
    n = 0;
    while (!cfg_ready && n < 30) begin step(); n++; end
    step();
    cfg_valid = 1'b0;
    drain("stale_drain");
    check("stale_no_tick", ticks_seen - t0, 0);
    check("stale_tick_count", {28'd0, tick_count}, 32'd0);
    do_stop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
